// File: rtl/mwb_pkg.sv
// Shared types and constants for the MEM/WB stage register.
// Field offsets used by the optional forwarding path (MWB_FWD_EN).
package mwb_pkg;

    localparam int MWB_PAYLOAD_W    = 96;
    localparam int MWB_DATA_W       = 32;
    localparam int MWB_RADDR_W      = 5;

    // Payload layout: bit 0 is MemtoReg, ALUOut sits at [63:32].
    localparam int MWB_MEMTOREG_BIT = 0;
    localparam int MWB_ALUOUT_LSB   = 32;

    typedef enum logic [0:0] {
        LD_IDLE = 1'b0,
        LD_HELD = 1'b1
    } ld_state_t;

endpackage

// File: rtl/mwb_ldbuf.sv
// One-entry side buffer holding early load data until its load
// leaves MEM; first captured data wins while held.
module mwb_ldbuf
    import mwb_pkg::*;
#(
    parameter int DATA_W = MWB_DATA_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              i_capture,
    input  logic              i_consume,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output ld_state_t         o_state
);

    ld_state_t         r_state;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= LD_IDLE;
            r_data  <= '0;
        end else if (i_clear || i_consume) begin
            r_state <= LD_IDLE;
        end else if (i_capture && r_state == LD_IDLE) begin
            r_state <= LD_HELD;
            r_data  <= i_data;
        end
    end

    assign o_data  = r_data;
    assign o_state = r_state;

endmodule

// File: rtl/mmwb_stage_reg.sv
// MEM/WB pipeline register with load-data alignment buffer.
// Define MWB_FWD_EN to add the fwd_* forwarding outputs.
module mmwb_stage_reg
    import mwb_pkg::*;
#(
    parameter int PAYLOAD_W = MWB_PAYLOAD_W,
    parameter int DATA_W    = MWB_DATA_W,
    parameter int RADDR_W   = MWB_RADDR_W
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 adv_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 in_valid,
    input  logic                 in_is_load,
    input  logic                 in_wen,
    input  logic [RADDR_W-1:0]   in_rd,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 dhit_i,
    input  logic [DATA_W-1:0]    dload_i,
    output logic                 ready_o,
    output logic                 out_valid,
    output logic                 out_wen,
    output logic [RADDR_W-1:0]   out_rd,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [DATA_W-1:0]    out_load
`ifdef MWB_FWD_EN
   ,output logic                 fwd_valid,
    output logic [RADDR_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0]    fwd_data
`endif
);

    logic                 r_valid;
    logic                 r_wen;
    logic [RADDR_W-1:0]   r_rd;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [DATA_W-1:0]    r_load;

    logic                 w_adv_eff;
    logic                 w_mem_load;
    logic                 w_ready;
    logic                 w_capture;
    logic [DATA_W-1:0]    w_buf_data;
    ld_state_t            w_state;

    assign w_adv_eff  = adv_i & ~stall_i & ~flush_i;
    assign w_mem_load = in_valid & in_is_load;
    assign w_ready    = ~(w_mem_load & (w_state == LD_IDLE) & ~dhit_i);
    // Stalls still capture: only a real advance consumes the hit directly.
    assign w_capture  = dhit_i & w_mem_load & ~w_adv_eff;

    mwb_ldbuf #(
        .DATA_W (DATA_W)
    ) u_ldbuf (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_capture (w_capture),
        .i_consume (w_adv_eff),
        .i_clear   (flush_i),
        .i_data    (dload_i),
        .o_data    (w_buf_data),
        .o_state   (w_state)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid   <= 1'b0;
            r_wen     <= 1'b0;
            r_rd      <= '0;
            r_payload <= '0;
            r_load    <= '0;
        end else if (flush_i) begin
            r_valid   <= 1'b0;
            r_wen     <= 1'b0;
        end else if (w_adv_eff) begin
            if (w_ready) begin
                r_valid   <= in_valid;
                r_wen     <= in_wen & in_valid;
                r_rd      <= in_rd;
                r_payload <= in_payload;
                if (w_mem_load) begin
                    r_load <= dhit_i ? dload_i : w_buf_data;
                end
            end else begin
                r_valid <= 1'b0;
                r_wen   <= 1'b0;
            end
        end
    end

    assign ready_o     = w_ready;
    assign out_valid   = r_valid;
    assign out_wen     = r_wen;
    assign out_rd      = r_rd;
    assign out_payload = r_payload;
    assign out_load    = r_load;

`ifdef MWB_FWD_EN
    assign fwd_valid = r_valid & r_wen;
    assign fwd_rd    = r_rd;
    assign fwd_data  = r_payload[MWB_MEMTOREG_BIT]
                     ? r_load
                     : r_payload[MWB_ALUOUT_LSB +: DATA_W];
`endif

endmodule
